process_scheduler: RTL and testbench

Process table and round-robin selector for the multiprogrammed CPU. Holds the saved PC and state of each user process, absorbs the PC/index pair the program counter emits on a context switch (quantum expiry or halt), and, on request from the OS, scans for the next ready process and presents its index and resume PC to the program counter's jProc path. Index 0 is reserved for BIOS/OS and is never stored or scheduled.

---
 rtl/process_scheduler.sv | 154 +++++++++++++++
 tb/tb_process_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/process_scheduler.sv
// Process table plus round-robin selector: stores saved PC/state per user process,
// absorbs context-switch saves, and scans for the next READY process on OS request.
module process_scheduler #(
  parameter int NUM_PROC = 32,
  parameter int IDX_W    = 5,
  parameter int ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              create_en,
  input  logic [IDX_W-1:0]  create_idx,
  input  logic [ADDR_W-1:0] create_pc,
  input  logic              save_en,
  input  logic [IDX_W-1:0]  save_idx,
  input  logic [ADDR_W-1:0] save_pc,
  input  logic              save_halt,
  input  logic              sched_req,
  output logic              sched_busy,
  output logic              sched_done,
  output logic              next_valid,
  output logic [IDX_W-1:0]  indice_prox_proc,
  output logic [ADDR_W-1:0] pc_prox_proc,
  output logic [IDX_W:0]    ready_count
);

  typedef enum logic [1:0] {E_FREE = 2'd0, E_READY = 2'd1, E_RUNNING = 2'd2} entry_t;
  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} sched_t;

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_PROC - 1);
  localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);
  localparam logic [IDX_W:0]   ONE_CNT = (IDX_W + 1)'(1);

  entry_t            r_state [NUM_PROC];
  entry_t            w_state_nxt [NUM_PROC];
  logic [ADDR_W-1:0] r_pc [NUM_PROC];

  sched_t           r_fsm, w_fsm_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_examined, w_examined_nxt;
  logic [IDX_W-1:0] r_last;
  logic             w_hit, w_done;
  logic [IDX_W:0]   w_ready_cnt;

  // Index 0 is reserved, so the pointer wraps from the top entry back to 1.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == MAX_IDX) ? ONE_IDX : idx + ONE_IDX;
  endfunction

  assign sched_busy = (r_fsm == S_SCAN);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm      <= S_IDLE;
      r_ptr      <= '0;
      r_examined <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_ptr      <= w_ptr_nxt;
      r_examined <= w_examined_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_ptr_nxt      = r_ptr;
    w_examined_nxt = r_examined;
    w_hit          = 1'b0;
    w_done         = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (sched_req) begin
          w_fsm_nxt      = S_SCAN;
          w_ptr_nxt      = wrap_inc(r_last);
          w_examined_nxt = '0;
        end
      end
      S_SCAN: begin
        if (r_state[r_ptr] == E_READY) begin
          w_hit     = 1'b1;
          w_done    = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else if (r_examined == MAX_IDX - ONE_IDX) begin
          w_done    = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else begin
          w_ptr_nxt      = wrap_inc(r_ptr);
          w_examined_nxt = r_examined + ONE_IDX;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Priority per entry: create over save over the scan's RUNNING mark.
  always_comb begin
    w_ready_cnt = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      w_state_nxt[i] = r_state[i];
      if (i != 0) begin
        if (w_hit && r_ptr == IDX_W'(i))
          w_state_nxt[i] = E_RUNNING;
        if (save_en && save_idx == IDX_W'(i))
          w_state_nxt[i] = save_halt ? E_FREE : E_READY;
        if (create_en && create_idx == IDX_W'(i))
          w_state_nxt[i] = E_READY;
      end
      if (w_state_nxt[i] == E_READY)
        w_ready_cnt = w_ready_cnt + ONE_CNT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROC; i++) begin
        r_state[i] <= E_FREE;
        r_pc[i]    <= '0;
      end
      ready_count <= '0;
    end else begin
      for (int i = 1; i < NUM_PROC; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (create_en && create_idx == IDX_W'(i))
          r_pc[i] <= create_pc;
        else if (save_en && save_idx == IDX_W'(i) && !save_halt)
          r_pc[i] <= save_pc;
      end
      ready_count <= w_ready_cnt;
    end
  end

  // Result registers hold until the next scan completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      sched_done       <= 1'b0;
      next_valid       <= 1'b0;
      indice_prox_proc <= '0;
      pc_prox_proc     <= '0;
      r_last           <= '0;
    end else begin
      sched_done <= w_done;
      if (w_hit) begin
        next_valid       <= 1'b1;
        indice_prox_proc <= r_ptr;
        pc_prox_proc     <= r_pc[r_ptr];
        r_last           <= r_ptr;
      end else if (w_done) begin
        next_valid       <= 1'b0;
        indice_prox_proc <= '0;
        pc_prox_proc     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: scheduling results are queued as expectations
// and checked by an independent monitor whenever sched_done pulses.
module tb_process_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        create_en = 1'b0;
  logic [4:0]  create_idx = '0;
  logic [15:0] create_pc = '0;
  logic        save_en = 1'b0;
  logic [4:0]  save_idx = '0;
  logic [15:0] save_pc = '0;
  logic        save_halt = 1'b0;
  logic        sched_req = 1'b0;
  logic        sched_busy, sched_done, next_valid;
  logic [4:0]  indice_prox_proc;
  logic [15:0] pc_prox_proc;
  logic [5:0]  ready_count;

  process_scheduler #(.NUM_PROC(32), .IDX_W(5), .ADDR_W(16)) dut (
    .clock(clock), .reset(reset),
    .create_en(create_en), .create_idx(create_idx), .create_pc(create_pc),
    .save_en(save_en), .save_idx(save_idx), .save_pc(save_pc), .save_halt(save_halt),
    .sched_req(sched_req), .sched_busy(sched_busy), .sched_done(sched_done),
    .next_valid(next_valid), .indice_prox_proc(indice_prox_proc),
    .pc_prox_proc(pc_prox_proc), .ready_count(ready_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [4:0]  idx;
    logic [15:0] pc;
    int          req_cyc;
    int          k;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per sched_done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (sched_done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("next_valid", {31'd0, next_valid}, {31'd0, e.valid});
        chk("indice", {27'd0, indice_prox_proc}, {27'd0, e.idx});
        chk("pc", {16'd0, pc_prox_proc}, {16'd0, e.pc});
        chk("latency", cyc - e.req_cyc, e.k);
        chk("busy_in_done", {31'd0, sched_busy}, 32'd0);
      end
    end
  end

  task automatic run_sched(input logic v, input logic [4:0] idx, input logic [15:0] pc,
                           input int k);
    exp_t e;
    @(negedge clock);
    sched_req = 1'b1;
    e.valid = v; e.idx = idx; e.pc = pc; e.req_cyc = cyc + 1; e.k = k;
    sb.push_back(e);
    @(negedge clock);
    sched_req = 1'b0;
    chk("busy_after_req", {31'd0, sched_busy}, 32'd1);
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clock);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none expected=sched_done within 40 cycles");
      void'(sb.pop_front());
    end
  endtask

  task automatic table_op(input logic ce, input logic [4:0] ci, input logic [15:0] cp,
                          input logic se, input logic [4:0] si, input logic [15:0] sp,
                          input logic sh);
    @(negedge clock);
    create_en = ce; create_idx = ci; create_pc = cp;
    save_en = se; save_idx = si; save_pc = sp; save_halt = sh;
    @(negedge clock);
    create_en = 1'b0; save_en = 1'b0; save_halt = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, sched_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, sched_done}, 32'd0);
    chk({tag, "_valid"}, {31'd0, next_valid}, 32'd0);
    chk({tag, "_indice"}, {27'd0, indice_prox_proc}, 32'd0);
    chk({tag, "_pc"}, {16'd0, pc_prox_proc}, 32'd0);
    chk({tag, "_ready"}, {26'd0, ready_count}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_idle_zero("reset");

    // Empty table: full 31-entry sweep, no hit.
    run_sched(1'b0, 5'd0, 16'h0000, 31);
    chk("ready_empty", {26'd0, ready_count}, 32'd0);

    table_op(1'b1, 5'd3, 16'h0100, 1'b0, 5'd0, 16'h0, 1'b0);
    chk("ready_c3", {26'd0, ready_count}, 32'd1);
    table_op(1'b1, 5'd7, 16'h0200, 1'b0, 5'd0, 16'h0, 1'b0);
    chk("ready_c7", {26'd0, ready_count}, 32'd2);
    run_sched(1'b1, 5'd3, 16'h0100, 3);
    chk("ready_after3", {26'd0, ready_count}, 32'd1);
    run_sched(1'b1, 5'd7, 16'h0200, 4);
    chk("ready_after7", {26'd0, ready_count}, 32'd0);
    chk("hold_indice", {27'd0, indice_prox_proc}, 32'd7);

    // Resume 3 with a new PC; last=7 so the scan wraps through 8..31,1,2,3.
    table_op(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 16'h0123, 1'b0);
    chk("ready_save3", {26'd0, ready_count}, 32'd1);
    run_sched(1'b1, 5'd3, 16'h0123, 27);

    table_op(1'b0, 5'd0, 16'h0, 1'b1, 5'd7, 16'h7777, 1'b1);
    chk("ready_halt7", {26'd0, ready_count}, 32'd0);

    table_op(1'b1, 5'd5, 16'h0500, 1'b1, 5'd5, 16'h0999, 1'b0);
    chk("ready_c5s5", {26'd0, ready_count}, 32'd1);
    table_op(1'b1, 5'd0, 16'hDEAD, 1'b1, 5'd0, 16'hBEEF, 1'b0);
    chk("ready_idx0", {26'd0, ready_count}, 32'd1);
    run_sched(1'b1, 5'd5, 16'h0500, 2);
    // Only RUNNING/FREE entries remain, halted 7 included.
    run_sched(1'b0, 5'd0, 16'h0000, 31);

    table_op(1'b1, 5'd9, 16'h0900, 1'b1, 5'd10, 16'h0A00, 1'b0);
    chk("ready_c9s10", {26'd0, ready_count}, 32'd2);
    run_sched(1'b1, 5'd9, 16'h0900, 4);
    run_sched(1'b1, 5'd10, 16'h0A00, 1);

    // Abort a scan that would hit entry 20 at k=10.
    table_op(1'b1, 5'd20, 16'h2000, 1'b0, 5'd0, 16'h0, 1'b0);
    chk("ready_c20", {26'd0, ready_count}, 32'd1);
    @(negedge clock);
    sched_req = 1'b1;
    @(negedge clock);
    sched_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_idle_zero("midscan_reset");
    repeat (12) @(negedge clock);
    run_sched(1'b0, 5'd0, 16'h0000, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
